// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - DataMover command/status types, field positions and chunk helper
package dm_pkg;

  localparam int CMD_W     = 72;
  localparam int BTT_LSB   = 0;
  localparam int BTT_W     = 23;
  localparam int TYPE_BIT  = 23;
  localparam int DSA_LSB   = 24;
  localparam int DSA_W     = 6;
  localparam int EOF_BIT   = 30;
  localparam int DRR_BIT   = 31;
  localparam int SADDR_LSB = 32;
  localparam int SADDR_W   = 32;
  localparam int TAG_LSB   = 64;
  localparam int TAG_W     = 4;
  localparam int RSVD_LSB  = 68;
  localparam int RSVD_W    = 4;

  typedef struct packed {
    logic [3:0]  rsvd;
    logic [3:0]  tag;
    logic [31:0] saddr;
    logic        drr;
    logic        eof;
    logic [5:0]  dsa;
    logic        typ;
    logic [22:0] btt;
  } dm_cmd_t;

  typedef struct packed {
    logic       okay;
    logic       slverr;
    logic       decerr;
    logic       interr;
    logic [3:0] tag;
  } dm_sts_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } dm_state_e;

  // Bytes that fit before the next max_chunk-aligned boundary, capped by rem.
  function automatic logic [22:0] dm_chunk(input logic [31:0] addr,
                                           input logic [22:0] rem,
                                           input logic [22:0] max_chunk);
    logic [22:0] off;
    logic [22:0] room;
    off  = addr[22:0] & (max_chunk - 23'd1);
    room = max_chunk - off;
    return (rem < room) ? rem : room;
  endfunction

endpackage

// File: rtl/dm_outstanding_cnt.sv
// rtl/dm_outstanding_cnt.sv - up/down count of sub-commands awaiting status
module dm_outstanding_cnt #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i) begin
      cnt_d = cnt_q + 4'd1;
    end else if (dec_i && !inc_i && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign full_o  = (cnt_q == 4'(MAX_OUTSTANDING));
  assign empty_o = (cnt_q == 4'd0);

endmodule

// File: rtl/dm_cmd_splitter.sv
// rtl/dm_cmd_splitter.sv - splits one DataMover command into boundary-aligned sub-commands
import dm_pkg::*;

module dm_cmd_splitter #(
  parameter int MAX_CHUNK_BYTES = 4096,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  input  logic [CMD_W-1:0]  pi_command,
  input  logic              pi_valid,
  output logic              po_ready,
  output logic [CMD_W-1:0]  po_dm_cmd,
  output logic              po_dm_cmd_valid,
  input  logic              pi_dm_cmd_ready,
  input  logic [7:0]        pi_dm_sts,
  input  logic              pi_dm_sts_valid,
  output logic              po_dm_sts_ready,
  output logic              po_done,
  output logic              po_error,
  input  logic              pi_error_clr
);

  localparam logic [22:0] CHUNK = 23'(MAX_CHUNK_BYTES);

  dm_state_e   state_q;
  dm_cmd_t     cmd_q;
  logic [31:0] addr_q;
  logic [22:0] rem_q;
  logic        eof_q;
  logic        ready_q;
  logic        valid_q;
  logic        done_q;
  logic        error_q;

  dm_cmd_t     in_cmd;
  dm_cmd_t     first_cmd;
  dm_cmd_t     next_cmd;
  logic [22:0] in_chunk;
  logic [22:0] nx_chunk;
  dm_sts_t     sts;
  logic        cmd_hs;
  logic        sts_hs;
  logic        sts_bad;
  logic        cnt_full;
  logic        cnt_empty;

  assign sts     = dm_sts_t'(pi_dm_sts);
  assign cmd_hs  = valid_q && pi_dm_cmd_ready;
  assign sts_hs  = pi_dm_sts_valid;
  // A status arriving with nothing outstanding is dropped and flagged.
  assign sts_bad = !sts.okay || sts.interr || sts.decerr || sts.slverr ||
                   (sts.tag != cmd_q.tag) || cnt_empty;

  always_comb begin
    in_cmd.btt   = pi_command[BTT_LSB +: BTT_W];
    in_cmd.typ   = pi_command[TYPE_BIT];
    in_cmd.dsa   = pi_command[DSA_LSB +: DSA_W];
    in_cmd.eof   = pi_command[EOF_BIT];
    in_cmd.drr   = pi_command[DRR_BIT];
    in_cmd.saddr = pi_command[SADDR_LSB +: SADDR_W];
    in_cmd.tag   = pi_command[TAG_LSB +: TAG_W];
    in_cmd.rsvd  = pi_command[RSVD_LSB +: RSVD_W];

    in_chunk      = dm_chunk(in_cmd.saddr, in_cmd.btt, CHUNK);
    first_cmd     = in_cmd;
    first_cmd.btt = in_chunk;
    first_cmd.eof = in_cmd.eof && (in_chunk == in_cmd.btt);

    nx_chunk       = dm_chunk(addr_q, rem_q, CHUNK);
    next_cmd       = cmd_q;
    next_cmd.saddr = addr_q;
    next_cmd.btt   = nx_chunk;
    next_cmd.drr   = 1'b0;
    next_cmd.eof   = eof_q && (nx_chunk == rem_q);
  end

  dm_outstanding_cnt #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_cnt (
    .clk_i   (S_AXI_ACLK),
    .rst_ni  (S_AXI_ARESETN),
    .inc_i   (cmd_hs),
    .dec_i   (sts_hs && !cnt_empty),
    .full_o  (cnt_full),
    .empty_o (cnt_empty)
  );

  // addr_q/rem_q always describe the sub-command after the one held in cmd_q.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      eof_q   <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (pi_valid && ready_q) begin
            ready_q <= 1'b0;
            cmd_q   <= first_cmd;
            addr_q  <= in_cmd.saddr + 32'(in_chunk);
            rem_q   <= in_cmd.btt - in_chunk;
            eof_q   <= in_cmd.eof;
            if (in_cmd.btt == 23'd0) begin
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_ISSUE;
              valid_q <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (cmd_hs) begin
            valid_q <= 1'b0;
            if (rem_q == 23'd0) begin
              state_q <= ST_DRAIN;
            end
          end else if (!valid_q && !cnt_full) begin
            valid_q <= 1'b1;
            cmd_q   <= next_cmd;
            addr_q  <= addr_q + 32'(nx_chunk);
            rem_q   <= rem_q - nx_chunk;
          end
        end
        ST_DRAIN: begin
          if (cnt_empty) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      error_q <= 1'b0;
    end else if (sts_hs && sts_bad) begin
      error_q <= 1'b1;
    end else if (pi_error_clr) begin
      error_q <= 1'b0;
    end
  end

  assign po_ready        = ready_q;
  assign po_dm_cmd       = cmd_q;
  assign po_dm_cmd_valid = valid_q;
  assign po_dm_sts_ready = 1'b1;
  assign po_done         = done_q;
  assign po_error        = error_q;

endmodule
